// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// memory_stage : RV32I load/store stage between execute and writeback.
//   Single-outstanding req/gnt/rvalid data bus; valid/ready result register.
// Revision : 1.0  initial release
// ============================================================================
module memory_stage #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] valE,
  input  logic [XLEN-1:0] valB,
  input  logic            cond,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [XLEN-1:0] out_valE,
  output logic [XLEN-1:0] out_valM,
  output logic            out_cond,
  output logic            out_misaligned
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  if (XLEN != 32 || ILEN != 32) begin : g_width_check
    $error("memory_stage supports only XLEN = ILEN = 32");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [6:0]      op_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] vale_q;
  logic            cond_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      wstrb_q;

  logic            out_valid_q, out_valid_d;
  logic [6:0]      out_op_q, out_op_d;
  logic [XLEN-1:0] out_vale_q, out_vale_d;
  logic [XLEN-1:0] out_valm_q, out_valm_d;
  logic            out_cond_q, out_cond_d;
  logic            out_mis_q, out_mis_d;

  logic            w_is_load, w_is_store, w_half, w_word, w_mis;
  logic            w_accept, w_bus_start, w_bypass, w_done;
  logic [XLEN-1:0] w_st_wdata;
  logic [3:0]      w_st_wstrb;
  logic [7:0]      w_byte;
  logic [15:0]     w_half_d;
  logic [XLEN-1:0] w_ld_val;

  assign w_is_load  = (opcode == OP_LOAD);
  assign w_is_store = (opcode == OP_STORE);
  assign w_half     = (w_is_load && (func3 == 3'b001 || func3 == 3'b101)) ||
                      (w_is_store && func3 == 3'b001);
  assign w_word     = (w_is_load || w_is_store) && (func3 == 3'b010);
  assign w_mis      = (w_half && valE[0]) || (w_word && (valE[1:0] != 2'b00));

  assign in_ready    = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_bus_start = w_accept && (w_is_load || w_is_store) && !w_mis;
  assign w_bypass    = w_accept && !w_bus_start;
  assign w_done      = (state_q == S_RESP) && mem_rvalid;

  // Store data is replicated across lanes; strobes pick the addressed bytes.
  always_comb begin
    w_st_wdata = valB;
    w_st_wstrb = 4'b0000;
    case (func3)
      3'b000: begin
        w_st_wdata = {4{valB[7:0]}};
        w_st_wstrb = 4'b0001 << valE[1:0];
      end
      3'b001: begin
        w_st_wdata = {2{valB[15:0]}};
        w_st_wstrb = valE[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        w_st_wdata = valB;
        w_st_wstrb = 4'b1111;
      end
      default: ;
    endcase
    if (!w_is_store) begin
      w_st_wstrb = 4'b0000;
    end
  end

  assign w_byte   = mem_rdata[{vale_q[1:0], 3'b000} +: 8];
  assign w_half_d = mem_rdata[{vale_q[1], 4'b0000} +: 16];

  always_comb begin
    w_ld_val = '0;
    case (f3_q)
      3'b000:  w_ld_val = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_ld_val = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_ld_val = {{(XLEN-16){w_half_d[15]}}, w_half_d};
      3'b101:  w_ld_val = {{(XLEN-16){1'b0}}, w_half_d};
      3'b010:  w_ld_val = mem_rdata;
      default: w_ld_val = '0;
    endcase
    if (op_q != OP_LOAD) begin
      w_ld_val = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_bus_start) state_d = S_REQ;
      S_REQ:   if (mem_gnt)     state_d = S_RESP;
      S_RESP:  if (mem_rvalid)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A bypass result and a bus completion can never coincide: accept needs IDLE.
  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_vale_d  = out_vale_q;
    out_valm_d  = out_valm_q;
    out_cond_d  = out_cond_q;
    out_mis_d   = out_mis_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_bypass) begin
      out_valid_d = 1'b1;
      out_op_d    = opcode;
      out_vale_d  = valE;
      out_valm_d  = '0;
      out_cond_d  = cond;
      out_mis_d   = w_mis;
    end else if (w_done) begin
      out_valid_d = 1'b1;
      out_op_d    = op_q;
      out_vale_d  = vale_q;
      out_valm_d  = w_ld_val;
      out_cond_d  = cond_q;
      out_mis_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      f3_q        <= '0;
      vale_q      <= '0;
      cond_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_vale_q  <= '0;
      out_valm_q  <= '0;
      out_cond_q  <= 1'b0;
      out_mis_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_vale_q  <= out_vale_d;
      out_valm_q  <= out_valm_d;
      out_cond_q  <= out_cond_d;
      out_mis_q   <= out_mis_d;
      if (w_bus_start) begin
        op_q    <= opcode;
        f3_q    <= func3;
        vale_q  <= valE;
        cond_q  <= cond;
        we_q    <= w_is_store;
        addr_q  <= {valE[XLEN-1:2], 2'b00};
        wdata_q <= w_st_wdata;
        wstrb_q <= w_st_wstrb;
      end
    end
  end

  assign mem_req        = (state_q == S_REQ);
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;
  assign out_valid      = out_valid_q;
  assign out_opcode     = out_op_q;
  assign out_valE       = out_vale_q;
  assign out_valM       = out_valm_q;
  assign out_cond       = out_cond_q;
  assign out_misaligned = out_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// tb_memory_stage : directed stimulus, scoreboarded result and bus checks.
module tb_memory_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] valE, valB;
  logic        cond;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [6:0]  out_opcode;
  logic [31:0] out_valE, out_valM;
  logic        out_cond, out_misaligned;

  memory_stage #(.XLEN(32), .ILEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .valE(valE), .valB(valB), .cond(cond),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_valE(out_valE), .out_valM(out_valM),
    .out_cond(out_cond), .out_misaligned(out_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] ve;
    logic [31:0] vm;
    logic        c;
    logic        mis;
    int          acc;
    int          lat;
  } out_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          chkw;
    int          gd;
    int          rd;
    logic [31:0] rdata;
  } bus_t;

  out_t sb[$];
  bus_t bq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] ve,
                       input logic [31:0] vb, input logic c, input logic [31:0] em,
                       input logic mis, input int lat, input bit busx, input logic we,
                       input logic [31:0] wd, input logic [3:0] ws, input bit chkw,
                       input int gd, input int rd, input logic [31:0] rdat, input bit pushout);
    bit   ok;
    out_t o;
    bus_t b;
    ok       = 1'b0;
    in_valid = 1'b1;
    opcode   = op;
    func3    = f3;
    valE     = ve;
    valB     = vb;
    cond     = c;
    for (int k = 0; k < 50 && !ok; k++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        o = '{op: op, ve: ve, vm: em, c: c, mis: mis, acc: cyc, lat: lat};
        if (pushout) sb.push_back(o);
        if (busx) begin
          b = '{we: we, addr: {ve[31:2], 2'b00}, wdata: wd, wstrb: ws, chkw: chkw,
                gd: gd, rd: rd, rdata: rdat};
          bq.push_back(b);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready expected accept of valE %0h", ve);
    end
  endtask

  task automatic op_i(input logic [6:0] op, input logic [31:0] ve, input logic c);
    issue(op, 3'b000, ve, 32'h0, c, 32'h0, 1'b0, 1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 0, 0, 32'h0, 1'b1);
  endtask

  task automatic ld_i(input logic [2:0] f3, input logic [31:0] ve, input logic [31:0] rdat,
                      input logic [31:0] em, input int gd, input int rd, input bit pushout);
    issue(7'h03, f3, ve, 32'h0, 1'b0, em, 1'b0, 3 + gd + rd, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0,
          gd, rd, rdat, pushout);
  endtask

  task automatic st_i(input logic [2:0] f3, input logic [31:0] ve, input logic [31:0] vb,
                      input logic [31:0] wd, input logic [3:0] ws, input int gd, input int rd);
    issue(7'h23, f3, ve, vb, 1'b0, 32'h0, 1'b0, 3 + gd + rd, 1'b1, 1'b1, wd, ws, 1'b1,
          gd, rd, 32'h0, 1'b1);
  endtask

  task automatic mis_i(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] ve);
    issue(op, f3, ve, 32'h5555_AAAA, 1'b0, 32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0,
          0, 0, 32'h0, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_bus"}, {mem_we, mem_addr, mem_wdata, mem_wstrb}, 69'h0);
    chk({tag, "_out_regs"}, {out_opcode, out_valE, out_valM, out_cond, out_misaligned}, 73'h0);
  endtask

  // Result monitor: latency on first sight, fields every valid cycle.
  bit head_seen = 1'b0;
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          e = sb[0];
          if (!head_seen) begin
            chk("out_latency", cyc - e.acc, e.lat);
            head_seen = 1'b1;
          end
          chk("out_fields", {out_opcode, out_valE, out_valM, out_cond, out_misaligned},
              {e.op, e.ve, e.vm, e.c, e.mis});
          if (!out_ready) begin
            chk("in_ready_while_held", in_ready, 1'b0);
          end else begin
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
      end
    end
  end

  // Bus monitor: every request cycle must match the pending transaction.
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      if (!rst && mem_req) begin
        if (bq.size() == 0) begin
          chk("unexpected_mem_req", mem_req, 1'b0);
        end else begin
          b = bq[0];
          chk("bus_addr_we", {mem_addr, mem_we}, {b.addr, b.we});
          if (b.chkw) chk("bus_wdata_wstrb", {mem_wdata, mem_wstrb}, {b.wdata, b.wstrb});
        end
      end
    end
  end

  // Memory responder driven from the pending transaction's timing.
  initial begin
    bus_t b;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hA5A5_A5A5;
    forever begin
      @(negedge clk);
      if (!rst && mem_req && bq.size() > 0) begin
        b = bq[0];
        for (int k = 0; k < b.gd; k++) begin
          @(negedge clk);
          chk("req_held_until_gnt", mem_req, 1'b1);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        void'(bq.pop_front());
        chk("req_drop_after_gnt", mem_req, 1'b0);
        for (int k = 0; k < b.rd; k++) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = b.rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hA5A5_A5A5;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; opcode = '0; func3 = '0; valE = '0; valB = '0;
    cond = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Pass-through results, back to back
    op_i(7'h33, 32'h0000_0042, 1'b0);
    op_i(7'h13, 32'h0000_0011, 1'b0);
    op_i(7'h13, 32'h0000_0022, 1'b1);
    op_i(7'h63, 32'h0000_0100, 1'b1);

    // Loads
    ld_i(3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 0, 0, 1'b1);
    ld_i(3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080, 0, 0, 1'b1);
    ld_i(3'b101, 32'h0000_1002, 32'h80FF_1234, 32'h0000_80FF, 0, 0, 1'b1);
    ld_i(3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 2, 1'b1);

    // Stores
    st_i(3'b001, 32'h0000_2002, 32'hABCD_1234, 32'h1234_1234, 4'b1100, 3, 0);
    st_i(3'b000, 32'h0000_2001, 32'h0000_005A, 32'h5A5A_5A5A, 4'b0010, 0, 0);
    st_i(3'b010, 32'h0000_2004, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 0, 1);

    // Misaligned accesses never reach the bus
    mis_i(7'h03, 3'b010, 32'h0000_3001);
    mis_i(7'h23, 3'b010, 32'h0000_3002);
    mis_i(7'h03, 3'b001, 32'h0000_3001);

    // Completed load held by downstream backpressure
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    ld_i(3'b001, 32'h0000_4002, 32'h8001_0000, 32'hFFFF_8001, 0, 0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset during RESP; late rvalid lands in the first cycle after reset
    ld_i(3'b010, 32'h0000_5000, 32'h1234_5678, 32'h0, 0, 1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    repeat (4) @(posedge clk);
    #1;
    op_i(7'h33, 32'h0000_0077, 1'b1);

    for (int k = 0; k < 100 && (sb.size() != 0 || bq.size() != 0); k++) @(posedge clk);
    chk("drain_pending", sb.size() + bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
